// File: rtl/uart_img_tx.sv
// Image read-back transmitter: fetches 12-bit pixel words, packs word pairs into
// three bytes and serialises them as 8N1 UART frames at OVERSAMPLE clocks per bit.
module uart_img_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int ADDR_W     = 19
) (
  input  logic              clk_uart,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] word_count,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BL_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_START, S_DATA, S_STOP, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [1:0]        phase, phase_nxt;
  logic              prep_cnt, prep_cnt_nxt;
  logic [BL_W-1:0]   bytes_left, bytes_left_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              tx_nxt, busy_nxt, done_nxt;
  logic [7:0]        shift, shift_nxt;
  logic [3:0]        w0_hi, w0_hi_nxt;
  logic [7:0]        w1_hi, w1_hi_nxt;

  logic [BL_W-1:0]   half, byte_total;
  logic              bit_end;

  // Bytes on the wire: 3 per full word pair, 2 for a trailing odd word.
  assign half       = BL_W'(word_count >> 1);
  assign byte_total = (half << 1) + half + (word_count[0] ? BL_W'(2) : BL_W'(0));
  assign bit_end    = (bit_cnt == BIT_LAST);

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    bit_idx_nxt    = bit_idx;
    phase_nxt      = phase;
    prep_cnt_nxt   = prep_cnt;
    bytes_left_nxt = bytes_left;
    rd_addr_nxt    = rd_addr;
    tx_nxt         = tx_out;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    shift_nxt      = shift;
    w0_hi_nxt      = w0_hi;
    w1_hi_nxt      = w1_hi;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_nxt      = S_PREP;
            rd_addr_nxt    = '0;
            phase_nxt      = 2'd0;
            prep_cnt_nxt   = 1'b0;
            bytes_left_nxt = byte_total;
            busy_nxt       = 1'b1;
          end else begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end
      end

      S_PREP: begin
        prep_cnt_nxt = 1'b1;
        // rd_data is only guaranteed on the second edge after rd_addr moves.
        if (prep_cnt) begin
          state_nxt   = S_START;
          bit_cnt_nxt = '0;
          tx_nxt      = 1'b0;
          case (phase)
            2'd0: begin
              w0_hi_nxt = rd_data[11:8];
              shift_nxt = rd_data[7:0];
            end
            2'd1: begin
              if (bytes_left == BL_W'(1)) begin
                shift_nxt = {4'h0, w0_hi};
              end else begin
                w1_hi_nxt = rd_data[11:4];
                shift_nxt = {rd_data[3:0], w0_hi};
              end
            end
            default: shift_nxt = w1_hi;
          endcase
        end
      end

      S_START: begin
        bit_cnt_nxt = bit_cnt + CNT_W'(1);
        if (bit_end) begin
          bit_cnt_nxt = '0;
          bit_idx_nxt = 3'd0;
          state_nxt   = S_DATA;
          tx_nxt      = shift[0];
        end
      end

      S_DATA: begin
        bit_cnt_nxt = bit_cnt + CNT_W'(1);
        if (bit_end) begin
          bit_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = {1'b0, shift[7:1]};
            tx_nxt      = shift[1];
          end
        end
      end

      S_STOP: begin
        bit_cnt_nxt = bit_cnt + CNT_W'(1);
        if (bit_end) begin
          bit_cnt_nxt    = '0;
          bytes_left_nxt = bytes_left - BL_W'(1);
          phase_nxt      = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
          prep_cnt_nxt   = 1'b0;
          if (bytes_left == BL_W'(1)) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_PREP;
            // Move the address right before the PREP that fetches from it.
            if ((phase == 2'd0 && bytes_left > BL_W'(2)) || phase == 2'd2)
              rd_addr_nxt = rd_addr + ADDR_W'(1);
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      phase      <= '0;
      prep_cnt   <= 1'b0;
      bytes_left <= '0;
      rd_addr    <= '0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      phase      <= phase_nxt;
      prep_cnt   <= prep_cnt_nxt;
      bytes_left <= bytes_left_nxt;
      rd_addr    <= rd_addr_nxt;
      tx_out     <= tx_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_ff @(posedge clk_uart) begin
    shift <= shift_nxt;
    w0_hi <= w0_hi_nxt;
    w1_hi <= w1_hi_nxt;
  end

endmodule

// File: tb/tb_uart_img_tx.sv
// Bench for uart_img_tx: per-cycle waveform model, UART receiver loopback and
// a pixel store that holds rd_data valid only on the second edge after an address update.
module tb_uart_img_tx;
  localparam int OS = 4;
  localparam int AW = 19;

  logic          clk_uart = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] word_count = '0;
  logic [AW-1:0] rd_addr;
  logic [11:0]   rd_data = '0;
  logic          tx_out, busy, done;

  always #5 clk_uart = ~clk_uart;

  uart_img_tx #(.OVERSAMPLE(OS), .ADDR_W(AW)) dut (
    .clk_uart(clk_uart), .rst_n(rst_n), .start(start), .word_count(word_count),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_out(tx_out), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic          tx;
    logic          busy;
    logic          done;
    logic          achk;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] mb[$];
  int         ma[$];
  logic [7:0] rxq[$];
  logic [11:0] mem[64];
  int  errors = 0;
  int  checks = 0;
  int  fail_prints = 0;
  bit  last_done = 1'b0;
  bit  start_evt = 1'b0;
  time t_e = 0;
  time t_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (fail_prints < 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      fail_prints++;
    end
  endtask

  task automatic push_e(input logic t, input logic b, input logic d, input logic a, input int ad);
    exp_t e;
    e.tx = t; e.busy = b; e.done = d; e.achk = a; e.addr = AW'(ad);
    expq.push_back(e);
  endtask

  // Byte stream straight from the packing rules.
  task automatic build_model(input int n);
    logic [11:0] w0, w1;
    mb.delete(); ma.delete();
    for (int k = 0; k < n / 2; k++) begin
      w0 = mem[2*k]; w1 = mem[2*k+1];
      mb.push_back(w0[7:0]);
      mb.push_back({w1[3:0], w0[11:8]});
      mb.push_back(w1[11:4]);
      ma.push_back(2*k); ma.push_back(2*k+1); ma.push_back(2*k+1);
    end
    if (n % 2 == 1) begin
      w0 = mem[n-1];
      mb.push_back(w0[7:0]);
      mb.push_back({4'h0, w0[11:8]});
      ma.push_back(n-1); ma.push_back(n-1);
    end
  endtask

  task automatic launch(input int n);
    logic [7:0] cur;
    logic       b;
    build_model(n);
    if (n == 0) begin
      push_e(1'b1, 1'b0, 1'b1, 1'b0, 0);
    end else begin
      repeat (2) push_e(1'b1, 1'b1, 1'b0, 1'b1, ma[0]);
      for (int k = 0; k < mb.size(); k++) begin
        cur = mb[k];
        for (int j = 0; j < 10; j++) begin
          b = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : cur[j-1];
          repeat (OS) push_e(b, 1'b1, 1'b0, 1'b1, ma[k]);
        end
        if (k < mb.size() - 1) repeat (2) push_e(1'b1, 1'b1, 1'b0, 1'b1, ma[k+1]);
      end
      push_e(1'b1, 1'b1, 1'b1, 1'b1, ma[mb.size()-1]);
    end
  endtask

  // One-cycle start; the model accepts it only if the block is idle at that edge.
  task automatic pulse(input int n);
    @(posedge clk_uart); #2;
    start = 1'b1; word_count = AW'(n);
    @(posedge clk_uart);
    if (expq.size() == 0 && !last_done) begin
      launch(n);
      start_evt = 1'b1;
      t_e = $time;
      t_done = 0;
    end
    #2 start = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 20000; i++) begin
      if (expq.size() == 0 && !last_done) break;
      @(posedge clk_uart);
    end
    if (i >= 20000) chk("idle_timeout", 1, 0);
    repeat (3) @(posedge clk_uart);
  endtask

  // Bytes seen on the line vs. model, and the receiver-side word rebuild vs. the store.
  task automatic check_rx(input int n);
    logic [7:0]  b0, b1, b2;
    logic [11:0] w;
    int idx;
    chk("byte_count", rxq.size(), mb.size());
    for (int i = 0; i < mb.size() && i < rxq.size(); i++) chk("byte", rxq[i], mb[i]);
    for (int k = 0; k < n / 2; k++) begin
      if (rxq.size() >= 3*k+3) begin
        b0 = rxq[3*k]; b1 = rxq[3*k+1]; b2 = rxq[3*k+2];
        w = {b1[3:0], b0};  chk("rebuild_w0", w, mem[2*k]);
        w = {b2, b1[7:4]};  chk("rebuild_w1", w, mem[2*k+1]);
      end
    end
    idx = 3 * (n / 2);
    if (n % 2 == 1 && rxq.size() >= idx + 2) begin
      b0 = rxq[idx]; b1 = rxq[idx+1];
      w = {b1[3:0], b0};
      chk("rebuild_odd", w, mem[n-1]);
      chk("odd_upper_nibble", b1[7:4], 4'h0);
    end
  endtask

  // Per-cycle compare against the expected waveform.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_uart);
      if (expq.size() > 0) e = expq.pop_front();
      else begin
        e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.achk = 1'b0; e.addr = '0;
      end
      last_done = e.done;
      if (done === 1'b1) t_done = $time;
      chk("tx_busy_done", {29'd0, tx_out, busy, done}, {29'd0, e.tx, e.busy, e.done});
      if (e.achk) chk("rd_addr", rd_addr, e.addr);
    end
  end

  // Pixel store: data valid only for the second edge after an address update.
  initial begin
    logic [AW-1:0] prev;
    int age;
    prev = '0; age = 10;
    forever begin
      @(posedge clk_uart); #1;
      if (start_evt || rd_addr !== prev) age = 0;
      else age++;
      start_evt = 1'b0;
      prev = rd_addr;
      rd_data = (age == 1) ? mem[rd_addr[5:0]] : 12'($urandom);
    end
  end

  // UART receiver sampling mid-bit.
  initial begin
    int mcnt;
    logic prev;
    logic [7:0] rb;
    mcnt = -1; prev = 1'b1; rb = '0;
    forever begin
      @(negedge clk_uart);
      if (!rst_n) begin
        mcnt = -1;
      end else if (mcnt < 0) begin
        if (prev && !tx_out) mcnt = 0;
      end else begin
        mcnt++;
        if (mcnt == OS/2) chk("start_bit", tx_out, 1'b0);
        if (mcnt % OS == OS/2 && mcnt / OS >= 1 && mcnt / OS <= 8) rb[mcnt/OS-1] = tx_out;
        if (mcnt == 9*OS + OS/2) begin
          chk("stop_bit", tx_out, 1'b1);
          rxq.push_back(rb);
          mcnt = -1;
        end
      end
      prev = tx_out;
    end
  end

  initial begin
    logic [7:0] lit_a[3];
    logic [7:0] lit_b[5];
    logic [7:0] lit_r[2];
    int n;
    lit_a = '{8'hBC, 8'h3A, 8'h12};
    lit_b = '{8'hFF, 8'h0F, 8'h00, 8'hA5, 8'h05};
    lit_r = '{8'h34, 8'h02};
    for (int i = 0; i < 64; i++) mem[i] = '0;

    #1 rst_n = 1'b0;
    #3;
    chk("reset_tx", tx_out, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_addr", rd_addr, '0);
    #18 rst_n = 1'b1;
    repeat (2) @(posedge clk_uart);

    // Two words, three bytes, done exactly 126 cycles after start.
    mem[0] = 12'hABC; mem[1] = 12'h123;
    rxq.delete();
    pulse(2);
    chk("model_pin_a", mb[1], 8'h3A);
    wait_idle();
    for (int i = 0; i < 3; i++) chk("bytes_a", (i < rxq.size()) ? rxq[i] : 8'hxx, lit_a[i]);
    chk("done_latency", 32'((t_done - t_e - 5) / 10), 126);
    check_rx(2);

    // Odd count with a forced-zero upper nibble on the last byte.
    mem[0] = 12'hFFF; mem[1] = 12'h000; mem[2] = 12'h5A5;
    rxq.delete();
    pulse(3);
    chk("model_pin_b", mb[4], 8'h05);
    wait_idle();
    for (int i = 0; i < 5; i++) chk("bytes_b", (i < rxq.size()) ? rxq[i] : 8'hxx, lit_b[i]);
    check_rx(3);

    // Zero words: done next cycle, nothing on the line.
    rxq.delete();
    pulse(0);
    wait_idle();
    chk("n0_no_bytes", rxq.size(), 0);
    chk("n0_done_cycle", 32'(t_done - t_e), 5);

    // Start re-pulsed while busy must not disturb the stream.
    for (int i = 0; i < 4; i++) mem[i] = 12'($urandom);
    rxq.delete();
    pulse(4);
    repeat (40) @(posedge clk_uart);
    pulse(7);
    wait_idle();
    check_rx(4);

    // Reset in the middle of a data bit.
    for (int i = 0; i < 4; i++) mem[i] = 12'($urandom);
    rxq.delete();
    pulse(4);
    repeat (2 + OS + 2) @(posedge clk_uart);
    #2 rst_n = 1'b0;
    expq.delete();
    last_done = 1'b0;
    #1;
    chk("midreset_tx", tx_out, 1'b1);
    chk("midreset_busy", busy, 1'b0);
    @(negedge clk_uart);
    @(posedge clk_uart); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk_uart);
    rxq.delete();
    mem[0] = 12'h234;
    pulse(1);
    wait_idle();
    for (int i = 0; i < 2; i++) chk("bytes_r", (i < rxq.size()) ? rxq[i] : 8'hxx, lit_r[i]);
    check_rx(1);

    // Randomised transfers, some with an ignored start mid-transfer.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) mem[i] = 12'($urandom);
      n = $urandom_range(1, 9);
      rxq.delete();
      pulse(n);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(5, 60)) @(posedge clk_uart);
        pulse($urandom_range(0, 9));
      end
      wait_idle();
      check_rx(n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
